// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state encoding and limits for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h10010000;
    localparam int          WAIT_STATES_MAX   = 15;
    localparam int          WCNT_W            = 4;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - synchronous-write, synchronous-read 32-bit word array
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wd,
    output logic [31:0]      rd
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wd;
        end
        rd <= mem[idx];
    end

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - load/store slave with wait states and address checking
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        error,
    output logic        busy
);

    localparam int                IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [32:0]       ADDR_LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
    localparam int                WS_M1      = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [WCNT_W-1:0] WCNT_INIT  = WCNT_W'(WS_M1);

    state_t            state, next_state;
    logic [WCNT_W-1:0] wcnt;
    logic [31:0]       cap_addr, cap_wdata, rdata_hold;
    logic              cap_we;

    logic              bad_addr;
    logic [31:0]       op_addr, op_wdata;
    logic              op_we, mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [31:0]       mem_rd;

    // The upper bound lives in 33 bits so addresses near 2^32 cannot wrap into range.
    assign bad_addr = (addr[1:0] != 2'b00) || (addr < BASE_ADDR) || ({1'b0, addr} >= ADDR_LIMIT);

    // With zero wait states the commit edge is the acceptance edge, so the live
    // inputs feed the array while idle; afterwards only the captured copy does.
    assign op_addr  = (state == IDLE) ? addr  : cap_addr;
    assign op_wdata = (state == IDLE) ? wdata : cap_wdata;
    assign op_we    = (state == IDLE) ? we    : cap_we;
    assign mem_idx  = IDX_W'((op_addr - BASE_ADDR) >> 2);
    assign mem_we   = (next_state == RESP) && op_we && !reset;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk(clk),
        .we (mem_we),
        .idx(mem_idx),
        .wd (op_wdata),
        .rd (mem_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wcnt       <= '0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_we     <= 1'b0;
            rdata_hold <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && req) begin
                cap_addr  <= addr;
                cap_wdata <= wdata;
                cap_we    <= we;
                if (!bad_addr) begin
                    wcnt <= WCNT_INIT;
                end
            end else if (state == WAIT && wcnt != '0) begin
                wcnt <= wcnt - 1'b1;
            end
            if (state == RESP && !cap_we) begin
                rdata_hold <= mem_rd;
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (bad_addr) begin
                        next_state = ERR;
                    end else if (WAIT_STATES == 0) begin
                        next_state = RESP;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT:    next_state = (wcnt == '0) ? RESP : WAIT;
            RESP:    next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The array output register doubles as rdata during a good load's ready cycle.
    always_comb begin
        ready = (state == RESP) || (state == ERR);
        error = (state == ERR);
        busy  = (state != IDLE);
        rdata = (state == RESP && !cap_we) ? mem_rd : rdata_hold;
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - scoreboard bench over three wait-state configurations
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        reset [3];
    logic        req   [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        ready [3];
    logic        error [3];
    logic        busy  [3];

    int vectors     = 0;
    int miscompares = 0;
    int ws_of [3]   = '{2, 0, 5};

    typedef struct {
        int          k;
        logic        err;
        logic        chk;
        logic [31:0] rd;
    } exp_t;

    exp_t sb [$];

    always #5 clk = ~clk;

    data_memory_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h10010000), .WAIT_STATES(2)) dut_ws2 (
        .clk(clk), .reset(reset[0]), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
        .rdata(rdata[0]), .ready(ready[0]), .error(error[0]), .busy(busy[0]));

    data_memory_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h10010000), .WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .reset(reset[1]), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
        .rdata(rdata[1]), .ready(ready[1]), .error(error[1]), .busy(busy[1]));

    data_memory_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h10010000), .WAIT_STATES(5)) dut_ws5 (
        .clk(clk), .reset(reset[2]), .req(req[2]), .we(we[2]), .addr(addr[2]), .wdata(wdata[2]),
        .rdata(rdata[2]), .ready(ready[2]), .error(error[2]), .busy(busy[2]));

    // Waits for ready (cycle-bounded), pops the scoreboard and checks response and latency.
    task automatic wait_and_check(input int k, input int start_cyc, input string name);
        exp_t e;
        int   cyc;
        int   lat;
        bit   got;
        cyc = start_cyc;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            got = (ready[k] === 1'b1);
        end
        req[k] = 1'b0;
        e   = sb.pop_front();
        lat = e.err ? 1 : ws_of[k] + 1;
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL %s timeout: no ready after %0d cycles, required %0d", name, cyc, lat);
        end else begin
            if (cyc != lat) begin
                miscompares++;
                $display("FAIL %s latency: got %0d required %0d", name, cyc, lat);
            end
            vectors++;
            if (error[k] !== e.err) begin
                miscompares++;
                $display("FAIL %s error: got %b required %b", name, error[k], e.err);
            end
            if (e.chk) begin
                vectors++;
                if (rdata[k] !== e.rd) begin
                    miscompares++;
                    $display("FAIL %s rdata: got %h required %h", name, rdata[k], e.rd);
                end
            end
        end
        @(negedge clk);
        vectors++;
        if (ready[k] !== 1'b0 || busy[k] !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle_after: ready=%b busy=%b required 0 0", name, ready[k], busy[k]);
        end
    endtask

    task automatic req_op(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic exp_err, input logic chk, input logic [31:0] exp_rd,
                          input string name);
        sb.push_back('{k, exp_err, chk, exp_rd});
        @(negedge clk);
        req[k]   = 1'b1;
        we[k]    = w;
        addr[k]  = a;
        wdata[k] = d;
        wait_and_check(k, 0, name);
    endtask

    task automatic test_reset;
        for (int k = 0; k < 3; k++) begin
            reset[k] = 1'b1;
            req[k]   = 1'b0;
            we[k]    = 1'b0;
            addr[k]  = '0;
            wdata[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) reset[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (ready[k] !== 1'b0 || error[k] !== 1'b0 || busy[k] !== 1'b0 || rdata[k] !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_state dut%0d: ready=%b error=%b busy=%b rdata=%h required 0 0 0 0",
                         k, ready[k], error[k], busy[k], rdata[k]);
            end
        end
    endtask

    task automatic test_store_load;
        req_op(0, 1'b1, 32'h10010008, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, "store_08");
        req_op(0, 1'b0, 32'h10010008, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, "load_08");
    endtask

    task automatic test_misaligned;
        req_op(0, 1'b1, 32'h10010004, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, "store_04");
        req_op(0, 1'b1, 32'h10010006, 32'hBAD0BAD0, 1'b1, 1'b1, 32'hDEADBEEF, "mis_store_06");
        req_op(0, 1'b0, 32'h10010006, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF, "mis_load_06");
        req_op(0, 1'b0, 32'h10010004, 32'h0, 1'b0, 1'b1, 32'hA5A5A5A5, "load_04_intact");
    endtask

    task automatic test_range;
        req_op(0, 1'b1, 32'h10010000, 32'h00000F00, 1'b0, 1'b0, 32'h0, "store_first");
        req_op(0, 1'b1, 32'h10010FFC, 32'h0FFC0FFC, 1'b0, 1'b0, 32'h0, "store_last");
        req_op(0, 1'b0, 32'h10010FFC, 32'h0, 1'b0, 1'b1, 32'h0FFC0FFC, "load_last");
        req_op(0, 1'b1, 32'h10011000, 32'h77777777, 1'b1, 1'b1, 32'h0FFC0FFC, "store_past_end");
        req_op(0, 1'b0, 32'h1000FFFC, 32'h0, 1'b1, 1'b1, 32'h0FFC0FFC, "load_below_base");
        req_op(0, 1'b1, 32'hFFFFFFFC, 32'h99999999, 1'b1, 1'b1, 32'h0FFC0FFC, "store_top_wrap");
        req_op(0, 1'b0, 32'h10010FFC, 32'h0, 1'b0, 1'b1, 32'h0FFC0FFC, "load_last_intact");
        req_op(0, 1'b0, 32'h10010000, 32'h0, 1'b0, 1'b1, 32'h00000F00, "load_first_intact");
    endtask

    task automatic test_back_to_back;
        exp_t e;
        bit   exp_rdy;
        req_op(1, 1'b1, 32'h10010000, 32'hCAFE0000, 1'b0, 1'b0, 32'h0, "b2b_store_00");
        req_op(1, 1'b1, 32'h10010004, 32'hCAFE0004, 1'b0, 1'b0, 32'h0, "b2b_store_04");
        sb.push_back('{1, 1'b0, 1'b1, 32'hCAFE0000});
        sb.push_back('{1, 1'b0, 1'b1, 32'hCAFE0004});
        @(negedge clk);
        req[1]  = 1'b1;
        we[1]   = 1'b0;
        addr[1] = 32'h10010000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_rdy = (i % 2 == 0);
            vectors++;
            if (ready[1] !== exp_rdy || busy[1] !== exp_rdy) begin
                miscompares++;
                $display("FAIL b2b_cycle%0d: ready=%b busy=%b required %b %b",
                         i, ready[1], busy[1], exp_rdy, exp_rdy);
            end
            if (exp_rdy && ready[1] === 1'b1) begin
                e = sb.pop_front();
                vectors++;
                if (rdata[1] !== e.rd || error[1] !== e.err) begin
                    miscompares++;
                    $display("FAIL b2b_data%0d: rdata=%h error=%b required %h %b",
                             i, rdata[1], error[1], e.rd, e.err);
                end
            end
            if (i == 0) addr[1] = 32'h10010004;
            if (i == 2) req[1] = 1'b0;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_drain: %0d responses missing, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_during_wait;
        req_op(2, 1'b1, 32'h10010010, 32'h0BADF00D, 1'b0, 1'b0, 32'h0, "rw_store_prior");
        req_op(2, 1'b0, 32'h10010010, 32'h0, 1'b0, 1'b1, 32'h0BADF00D, "rw_load_prior");
        @(negedge clk);
        req[2]   = 1'b1;
        we[2]    = 1'b1;
        addr[2]  = 32'h10010010;
        wdata[2] = 32'h12345678;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            vectors++;
            if (ready[2] !== 1'b0) begin
                miscompares++;
                $display("FAIL rw_no_ready cycle %0d: ready=%b required 0", i, ready[2]);
            end
            if (i == 3) begin
                reset[2] = 1'b1;
                req[2]   = 1'b0;
            end
            if (i == 5) reset[2] = 1'b0;
        end
        vectors++;
        if (busy[2] !== 1'b0 || rdata[2] !== 32'h0) begin
            miscompares++;
            $display("FAIL rw_after_reset: busy=%b rdata=%h required 0 00000000", busy[2], rdata[2]);
        end
        req_op(2, 1'b0, 32'h10010010, 32'h0, 1'b0, 1'b1, 32'h0BADF00D, "rw_load_after");
    endtask

    task automatic test_input_change;
        req_op(0, 1'b1, 32'h10010024, 32'h24242424, 1'b0, 1'b0, 32'h0, "ic_store_24");
        sb.push_back('{0, 1'b0, 1'b0, 32'h0});
        @(negedge clk);
        req[0]   = 1'b1;
        we[0]    = 1'b1;
        addr[0]  = 32'h10010020;
        wdata[0] = 32'h55AA55AA;
        @(negedge clk);
        addr[0]  = 32'h10010024;
        wdata[0] = 32'hFFFFFFFF;
        we[0]    = 1'b0;
        wait_and_check(0, 1, "ic_store_20");
        req_op(0, 1'b0, 32'h10010020, 32'h0, 1'b0, 1'b1, 32'h55AA55AA, "ic_load_20");
        req_op(0, 1'b0, 32'h10010024, 32'h0, 1'b0, 1'b1, 32'h24242424, "ic_load_24");
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_misaligned();
        test_range();
        test_back_to_back();
        test_reset_during_wait();
        test_input_change();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
